codec_twi_arbiter: RTL and testbench

//  Shares one TWICtl instance between two requesters that each issue single ADAU1761 register writes
//  (0x40xx-style 16-bit register address plus one data byte). Typical requesters are the init

---
 rtl/codec_twi_arbiter_if.sv | 38 +++
 rtl/codec_twi_arbiter.sv | 174 +++++++++++++++++
 tb/tb_codec_twi_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/codec_twi_arbiter_if.sv
// Requester and TWICtl handshake bundle for codec_twi_arbiter.
// The master modport is the arbiter's view; the slave modport is the
// requester/TWICtl side.
interface codec_twi_arbiter_if;
  logic        req0_vld;
  logic [15:0] req0_addr;
  logic [7:0]  req0_data;
  logic        req0_done;
  logic        req0_err;
  logic        req1_vld;
  logic [15:0] req1_addr;
  logic [7:0]  req1_data;
  logic        req1_done;
  logic        req1_err;
  logic        busy;
  logic        twi_msg;
  logic        twi_stb;
  logic [7:0]  twi_addr;
  logic [7:0]  twi_din;
  logic        twi_done;
  logic        twi_err;

  modport master (
    input  req0_vld, req0_addr, req0_data,
    input  req1_vld, req1_addr, req1_data,
    input  twi_done, twi_err,
    output req0_done, req0_err, req1_done, req1_err,
    output busy, twi_msg, twi_stb, twi_addr, twi_din
  );

  modport slave (
    output req0_vld, req0_addr, req0_data,
    output req1_vld, req1_addr, req1_data,
    output twi_done, twi_err,
    input  req0_done, req0_err, req1_done, req1_err,
    input  busy, twi_msg, twi_stb, twi_addr, twi_din
  );
endinterface

// File: rtl/codec_twi_arbiter.sv
// Round-robin arbiter sharing one TWICtl between two single-register
// ADAU1761 writers. Sends addr_hi/addr_lo/data as one message, retries
// failed attempts and enforces an idle gap after every attempt.
module codec_twi_arbiter #(
  parameter logic [6:0]  DEV_ADDR   = 7'b0111011,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 24000
) (
  input logic                 clk,
  input logic                 rst,
  codec_twi_arbiter_if.master bus
);

  localparam int unsigned       RW          = $clog2(MAX_RETRY + 1);
  localparam int unsigned       GW          = $clog2(GAP_CYCLES + 1);
  localparam logic [RW-1:0]     RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [GW-1:0]     GAP_LAST    = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_FAIL,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_gnt;
  logic            r_rr_last;
  logic [15:0]     r_addr;
  logic [7:0]      r_data;
  logic [RW-1:0]   r_retry;
  logic            r_retry_pend;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_done0;
  logic            r_done1;
  logic            r_err0;
  logic            r_err1;

  logic            w_any_vld;
  logic            w_pick;
  logic            w_gap_end;
  logic [RW-1:0]   w_retry_next;
  logic            w_stb;
  logic            w_msg;
  logic [7:0]      w_din;
  logic            w_busy;

  assign w_any_vld    = bus.req0_vld | bus.req1_vld;
  // On a tie the requester that was not served last wins.
  assign w_pick       = (bus.req0_vld & bus.req1_vld) ? ~r_rr_last : bus.req1_vld;
  assign w_gap_end    = (r_gap_cnt == GAP_LAST);
  assign w_retry_next = r_retry + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any_vld) w_next = S_GRANT;
      S_GRANT:   w_next = S_ADDR_HI;
      S_ADDR_HI: if (bus.twi_done) w_next = bus.twi_err ? S_FAIL : S_ADDR_LO;
      S_ADDR_LO: if (bus.twi_done) w_next = bus.twi_err ? S_FAIL : S_DATA;
      S_DATA:    if (bus.twi_done) w_next = bus.twi_err ? S_FAIL : S_GAP;
      S_FAIL:    w_next = S_GAP;
      S_GAP:     if (w_gap_end) w_next = r_retry_pend ? S_ADDR_HI : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // TWICtl byte drive and busy, decoded from the current state.
  always_comb begin
    w_stb  = 1'b0;
    w_msg  = 1'b0;
    w_din  = '0;
    w_busy = (r_state != S_IDLE);
    case (r_state)
      S_ADDR_HI: begin
        w_stb = 1'b1;
        w_msg = 1'b1;
        w_din = r_addr[15:8];
      end
      S_ADDR_LO: begin
        w_stb = 1'b1;
        w_din = r_addr[7:0];
      end
      S_DATA: begin
        w_stb = 1'b1;
        w_din = r_data;
      end
      default: ;
    endcase
  end

  // Grant, latched transaction, retry/gap bookkeeping and result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt        <= 1'b0;
      r_rr_last    <= 1'b1;
      r_addr       <= '0;
      r_data       <= '0;
      r_retry      <= '0;
      r_retry_pend <= 1'b0;
      r_gap_cnt    <= '0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;

      if (r_state == S_GAP && !w_gap_end) r_gap_cnt <= r_gap_cnt + 1'b1;
      else                                r_gap_cnt <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_any_vld) r_gnt <= w_pick;
        end
        S_GRANT: begin
          r_addr       <= r_gnt ? bus.req1_addr : bus.req0_addr;
          r_data       <= r_gnt ? bus.req1_data : bus.req0_data;
          r_rr_last    <= r_gnt;
          r_retry      <= '0;
          r_retry_pend <= 1'b0;
        end
        S_DATA: begin
          if (bus.twi_done && !bus.twi_err) begin
            r_done0 <= ~r_gnt;
            r_done1 <= r_gnt;
          end
        end
        S_FAIL: begin
          r_retry <= w_retry_next;
          if (w_retry_next == RETRY_LIMIT) begin
            r_err0       <= ~r_gnt;
            r_err1       <= r_gnt;
            r_retry_pend <= 1'b0;
          end else begin
            r_retry_pend <= 1'b1;
          end
        end
        S_GAP: begin
          // Consume the retry flag on the way out so a later success
          // cannot loop back into another attempt.
          if (w_gap_end) r_retry_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.twi_stb   = w_stb;
  assign bus.twi_msg   = w_msg;
  assign bus.twi_din   = w_din;
  assign bus.twi_addr  = {DEV_ADDR, 1'b0};
  assign bus.busy      = w_busy;
  assign bus.req0_done = r_done0;
  assign bus.req1_done = r_done1;
  assign bus.req0_err  = r_err0;
  assign bus.req1_err  = r_err1;

endmodule

// File: tb/tb_codec_twi_arbiter.sv
// Directed bench for codec_twi_arbiter with a behavioural TWICtl responder.
module tb_codec_twi_arbiter;
  localparam int unsigned GAP     = 8;
  localparam int unsigned RETRIES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  codec_twi_arbiter_if bus();

  codec_twi_arbiter #(
    .DEV_ADDR  (7'b0111011),
    .MAX_RETRY (RETRIES),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // monitor / model state (written only by the negedge process)
  int         n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0, n_both = 0;
  int         n_lo_err = 0;
  int         byte_idx = 0;
  int         low_run = 0;
  int         pulse_q[$];
  logic [8:0] byte_q[$];
  int         gap_q[$];

  // error injection controls (written only by the stimulus process)
  int         err_lo_limit = 0;
  bit         err_data_always = 1'b0;

  // Pulse monitor plus TWICtl model: acks a strobed byte one half-cycle later.
  always @(negedge clk) begin
    if (bus.req0_done) begin n_done0++; pulse_q.push_back(0); end
    if (bus.req1_done) begin n_done1++; pulse_q.push_back(1); end
    if (bus.req0_err)  begin n_err0++;  pulse_q.push_back(2); end
    if (bus.req1_err)  begin n_err1++;  pulse_q.push_back(3); end
    if ((bus.req0_done | bus.req1_done) && (bus.req0_err | bus.req1_err)) n_both++;
    if ((bus.req0_done && bus.req1_done) || (bus.req0_err && bus.req1_err)) n_both++;
    if (bus.twi_stb === 1'b1) begin
      if (low_run > 0) gap_q.push_back(low_run);
      low_run = 0;
    end else begin
      low_run++;
    end
    if (bus.twi_stb === 1'b1 && bus.twi_done !== 1'b1) begin
      byte_idx = bus.twi_msg ? 0 : byte_idx + 1;
      byte_q.push_back({bus.twi_msg, bus.twi_din});
      bus.twi_done = 1'b1;
      if (byte_idx == 1 && n_lo_err < err_lo_limit) begin
        bus.twi_err = 1'b1;
        n_lo_err++;
      end else begin
        bus.twi_err = (byte_idx == 2) && err_data_always;
      end
    end else begin
      bus.twi_done = 1'b0;
      bus.twi_err  = 1'b0;
    end
  end

  function automatic int total_pulses();
    return n_done0 + n_done1 + n_err0 + n_err1;
  endfunction

  function automatic int msg_starts(input int from);
    int n = 0;
    for (int i = from; i < byte_q.size(); i++) if (byte_q[i][8]) n++;
    return n;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (total_pulses() >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin tick(); n++; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
    err_data_always = 1'b0;
    err_lo_limit = n_lo_err;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_addr = '0; bus.req1_data = '0;
    do_reset();
    tick();
    n_checks++; if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.twi_stb !== 1'b0)   begin n_bad++; $display("FAIL reset_stb: got %b want 0", bus.twi_stb); end
    n_checks++; if (bus.twi_msg !== 1'b0)   begin n_bad++; $display("FAIL reset_msg: got %b want 0", bus.twi_msg); end
    n_checks++; if (bus.twi_din !== 8'h00)  begin n_bad++; $display("FAIL reset_din: got %h want 00", bus.twi_din); end
    n_checks++; if (bus.twi_addr !== 8'h76) begin n_bad++; $display("FAIL reset_addr: got %h want 76", bus.twi_addr); end
    n_checks++; if ({bus.req0_done, bus.req0_err, bus.req1_done, bus.req1_err} !== 4'b0000)
      begin n_bad++; $display("FAIL reset_pulses: got %b want 0000", {bus.req0_done, bus.req0_err, bus.req1_done, bus.req1_err}); end
  endtask

  task automatic test_single();
    int b, d0, e0, d1, n; bit ok;
    do_reset();
    b = byte_q.size(); d0 = n_done0; e0 = n_err0; d1 = n_done1;
    bus.req0_addr = 16'h4015; bus.req0_data = 8'h01; bus.req0_vld = 1'b1;
    wait_pulses(total_pulses() + 1, 200, ok);
    n_checks++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got no pulse want one"); end
    bus.req0_vld = 1'b0;
    wait_idle(n);
    n_checks++; if (n != GAP) begin n_bad++; $display("FAIL single_gap: got %0d want %0d", n, GAP); end
    n_checks++; if (byte_q.size() - b != 3) begin n_bad++; $display("FAIL single_nbytes: got %0d want 3", byte_q.size() - b); end
    n_checks++; if (byte_q[b] !== 9'h140)   begin n_bad++; $display("FAIL single_b0: got %h want 140", byte_q[b]); end
    n_checks++; if (byte_q[b+1] !== 9'h015) begin n_bad++; $display("FAIL single_b1: got %h want 015", byte_q[b+1]); end
    n_checks++; if (byte_q[b+2] !== 9'h001) begin n_bad++; $display("FAIL single_b2: got %h want 001", byte_q[b+2]); end
    n_checks++; if (n_done0 - d0 != 1) begin n_bad++; $display("FAIL single_done0: got %0d want 1", n_done0 - d0); end
    n_checks++; if (n_err0 - e0 != 0 || n_done1 - d1 != 0)
      begin n_bad++; $display("FAIL single_other: got err0=%0d done1=%0d want 0", n_err0 - e0, n_done1 - d1); end
    n_checks++; if (bus.twi_stb !== 1'b0) begin n_bad++; $display("FAIL single_idle_stb: got %b want 0", bus.twi_stb); end
  endtask

  task automatic test_round_robin();
    int p, n; bit ok;
    do_reset();
    p = pulse_q.size();
    bus.req0_addr = 16'h4010; bus.req0_data = 8'h11;
    bus.req1_addr = 16'h4020; bus.req1_data = 8'h22;
    bus.req0_vld = 1'b1; bus.req1_vld = 1'b1;
    wait_pulses(total_pulses() + 4, 400, ok);
    bus.req0_vld = 1'b0; bus.req1_vld = 1'b0;
    n_checks++; if (!ok) begin n_bad++; $display("FAIL rr_timeout: got %0d pulses want 4", pulse_q.size() - p); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pulse_q[p+i] != (i % 2)) begin n_bad++; $display("FAIL rr_order%0d: got %0d want %0d", i, pulse_q[p+i], i % 2); end
    end
    wait_idle(n);
    n_checks++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rr_idle: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_retry();
    int b, g, d1, e1, n; bit ok;
    do_reset();
    b = byte_q.size(); g = gap_q.size(); d1 = n_done1; e1 = n_err1;
    err_lo_limit = n_lo_err + 2;
    bus.req1_addr = 16'h4080; bus.req1_data = 8'h3C; bus.req1_vld = 1'b1;
    wait_pulses(total_pulses() + 1, 300, ok);
    bus.req1_vld = 1'b0;
    n_checks++; if (!ok) begin n_bad++; $display("FAIL retry_timeout: got no pulse want one"); end
    n_checks++; if (n_done1 - d1 != 1 || n_err1 - e1 != 0)
      begin n_bad++; $display("FAIL retry_result: got done1=%0d err1=%0d want 1 0", n_done1 - d1, n_err1 - e1); end
    n_checks++; if (msg_starts(b) != 3) begin n_bad++; $display("FAIL retry_starts: got %0d want 3", msg_starts(b)); end
    n_checks++; if (byte_q.size() - b != 7) begin n_bad++; $display("FAIL retry_nbytes: got %0d want 7", byte_q.size() - b); end
    n_checks++; if ({byte_q[b+4], byte_q[b+5], byte_q[b+6]} !== {9'h140, 9'h080, 9'h03C})
      begin n_bad++; $display("FAIL retry_bytes: got %h %h %h want 140 080 03c", byte_q[b+4], byte_q[b+5], byte_q[b+6]); end
    n_checks++; if (gap_q.size() - g != 3) begin n_bad++; $display("FAIL retry_ngaps: got %0d want 3", gap_q.size() - g); end
    n_checks++; if (gap_q[g+1] != GAP + 1 || gap_q[g+2] != GAP + 1)
      begin n_bad++; $display("FAIL retry_gaplen: got %0d %0d want %0d", gap_q[g+1], gap_q[g+2], GAP + 1); end
    wait_idle(n);
  endtask

  task automatic test_max_retry();
    int b, d0, e0, t, n; bit ok;
    do_reset();
    b = byte_q.size(); d0 = n_done0; e0 = n_err0;
    err_data_always = 1'b1;
    bus.req0_addr = 16'h4016; bus.req0_data = 8'h55; bus.req0_vld = 1'b1;
    wait_pulses(total_pulses() + 1, 400, ok);
    bus.req0_vld = 1'b0;
    n_checks++; if (!ok) begin n_bad++; $display("FAIL maxr_timeout: got no pulse want one"); end
    n_checks++; if (n_err0 - e0 != 1 || n_done0 - d0 != 0)
      begin n_bad++; $display("FAIL maxr_result: got err0=%0d done0=%0d want 1 0", n_err0 - e0, n_done0 - d0); end
    n_checks++; if (msg_starts(b) != RETRIES) begin n_bad++; $display("FAIL maxr_attempts: got %0d want %0d", msg_starts(b), RETRIES); end
    n_checks++; if (byte_q.size() - b != 9) begin n_bad++; $display("FAIL maxr_nbytes: got %0d want 9", byte_q.size() - b); end
    wait_idle(n);
    t = total_pulses();
    for (int i = 0; i < 30; i++) tick();
    n_checks++; if (total_pulses() != t || bus.busy !== 1'b0)
      begin n_bad++; $display("FAIL maxr_after: got pulses=%0d busy=%b want 0 0", total_pulses() - t, bus.busy); end
    err_data_always = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int t, b, d0, n; bit found, ok;
    do_reset();
    bus.req0_addr = 16'h4015; bus.req0_data = 8'h01; bus.req0_vld = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (bus.twi_stb === 1'b1 && bus.twi_msg === 1'b0) found = 1'b1;
    end
    n_checks++; if (!found) begin n_bad++; $display("FAIL rstmid_reach: got no ADDR_LO want ADDR_LO"); end
    t = total_pulses();
    rst = 1'b1; bus.req0_vld = 1'b0;
    tick();
    rst = 1'b0;
    n_checks++; if ({bus.twi_stb, bus.twi_msg, bus.busy} !== 3'b000)
      begin n_bad++; $display("FAIL rstmid_outs: got stb/msg/busy=%b want 000", {bus.twi_stb, bus.twi_msg, bus.busy}); end
    for (int i = 0; i < 30; i++) tick();
    n_checks++; if (total_pulses() != t) begin n_bad++; $display("FAIL rstmid_nopulse: got %0d want 0", total_pulses() - t); end
    b = byte_q.size(); d0 = n_done0;
    bus.req0_addr = 16'h4017; bus.req0_data = 8'h7E; bus.req0_vld = 1'b1;
    wait_pulses(total_pulses() + 1, 200, ok);
    bus.req0_vld = 1'b0;
    n_checks++; if (!ok || n_done0 - d0 != 1) begin n_bad++; $display("FAIL rstmid_regrant: got done0=%0d want 1", n_done0 - d0); end
    n_checks++; if ({byte_q[b], byte_q[b+1], byte_q[b+2]} !== {9'h140, 9'h017, 9'h07E})
      begin n_bad++; $display("FAIL rstmid_bytes: got %h %h %h want 140 017 07e", byte_q[b], byte_q[b+1], byte_q[b+2]); end
    wait_idle(n);
  endtask

  task automatic test_latch();
    int b, d0, t, n; bit found, ok;
    do_reset();
    b = byte_q.size(); d0 = n_done0; t = total_pulses();
    bus.req0_addr = 16'h40F2; bus.req0_data = 8'hA5; bus.req0_vld = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (bus.twi_stb === 1'b1 && bus.twi_msg === 1'b1) found = 1'b1;
    end
    bus.req0_addr = 16'h1234; bus.req0_data = 8'h00; bus.req0_vld = 1'b0;
    n_checks++; if (!found) begin n_bad++; $display("FAIL latch_reach: got no ADDR_HI want ADDR_HI"); end
    wait_pulses(t + 1, 200, ok);
    n_checks++; if (!ok || n_done0 - d0 != 1) begin n_bad++; $display("FAIL latch_done: got done0=%0d want 1", n_done0 - d0); end
    n_checks++; if ({byte_q[b], byte_q[b+1], byte_q[b+2]} !== {9'h140, 9'h0F2, 9'h0A5})
      begin n_bad++; $display("FAIL latch_bytes: got %h %h %h want 140 0f2 0a5", byte_q[b], byte_q[b+1], byte_q[b+2]); end
    wait_idle(n);
    n_checks++; if (n_done0 - d0 != 1) begin n_bad++; $display("FAIL latch_once: got %0d want 1", n_done0 - d0); end
  endtask

  initial begin
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_retry();
    test_max_retry();
    test_reset_midflight();
    test_latch();
    n_checks++; if (n_both != 0) begin n_bad++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", n_both); end
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
